// File: rtl/ppu_mem_responder.sv
// PPU/CPU responder for OAM and VRAM with mode-based CPU locking.
// Optional OAM DMA engine enabled by defining OAM_DMA_EN.
module ppu_mem_responder #(
   parameter int READ_LATENCY        = 1,
   parameter int VRAM_BYTES          = 8192,
   parameter int OAM_BYTES           = 160,
   parameter int DMA_CYCLES_PER_BYTE = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        ppu_req_in,
   input  logic [15:0] ppu_addr_in,
   output logic [7:0]  ppu_data_out,
   output logic        ppu_data_valid_out,
   input  logic        cpu_re_in,
   input  logic        cpu_we_in,
   input  logic [15:0] cpu_addr_in,
   input  logic [7:0]  cpu_wdata_in,
   output logic [7:0]  cpu_rdata_out,
   output logic        cpu_rvalid_out,
   input  logic [1:0]  mode_in,
   input  logic        lcd_en_in,
   output logic        dma_req_out,
   output logic [15:0] dma_addr_out,
   input  logic [7:0]  dma_data_in,
   input  logic        dma_valid_in,
   output logic        dma_active_out
);

   localparam int          VAW      = $clog2(VRAM_BYTES);
   localparam logic [15:0] OAM_BASE = 16'hFE00;
   localparam logic [15:0] OAM_END  = 16'(16'hFE00 + OAM_BYTES);

   logic [7:0] vram [VRAM_BYTES];
   logic [7:0] oam  [OAM_BYTES];

   logic       ppu_vram_hit, ppu_oam_hit;
   logic       cpu_vram_hit, cpu_oam_hit;
   logic       oam_lock, vram_lock;
   logic       dma_active;
   logic       dma_wr;
   logic [7:0] dma_widx;
   logic [7:0] dma_wdata;
   logic [7:0] ppu_rd, cpu_rd;
   logic       cpu_rd_en, cpu_vram_wr, cpu_oam_wr;

   assign ppu_vram_hit = ppu_addr_in[15:13] == 3'b100;
   assign ppu_oam_hit  = ppu_addr_in >= OAM_BASE && ppu_addr_in < OAM_END;
   assign cpu_vram_hit = cpu_addr_in[15:13] == 3'b100;
   assign cpu_oam_hit  = cpu_addr_in >= OAM_BASE && cpu_addr_in < OAM_END;

   assign oam_lock  = (lcd_en_in & (mode_in == 2'd2 | mode_in == 2'd3))
                    | dma_active;
   assign vram_lock = lcd_en_in & (mode_in == 2'd3);

   assign cpu_rd_en   = cpu_re_in & ~cpu_we_in;
   assign cpu_vram_wr = cpu_we_in & cpu_vram_hit & ~vram_lock;
   assign cpu_oam_wr  = cpu_we_in & cpu_oam_hit & ~oam_lock;

   // PPU reads ignore every lock, including DMA.
   always_comb begin
      ppu_rd = 8'hFF;
      unique case (1'b1)
         ppu_vram_hit: ppu_rd = vram[ppu_addr_in[VAW-1:0]];
         ppu_oam_hit:  ppu_rd = oam[ppu_addr_in[7:0]];
         default:      ppu_rd = 8'hFF;
      endcase
   end

   always_comb begin
      cpu_rd = 8'hFF;
      unique case (1'b1)
         cpu_vram_hit: cpu_rd = vram_lock ? 8'hFF : vram[cpu_addr_in[VAW-1:0]];
         cpu_oam_hit:  cpu_rd = oam_lock ? 8'hFF : oam[cpu_addr_in[7:0]];
         default:      cpu_rd = 8'hFF;
      endcase
   end

   // Arrays keep their contents across reset.
   always_ff @(posedge clk_in) begin
      if (cpu_vram_wr)
         vram[cpu_addr_in[VAW-1:0]] <= cpu_wdata_in;
      if (dma_wr)
         oam[dma_widx] <= dma_wdata;
      else if (cpu_oam_wr)
         oam[cpu_addr_in[7:0]] <= cpu_wdata_in;
   end

   logic [READ_LATENCY-1:0] ppu_v, cpu_v;
   logic [7:0]              ppu_d [READ_LATENCY];
   logic [7:0]              cpu_d [READ_LATENCY];

   // Data stages only advance behind a valid, so the last stage holds.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ppu_v <= '0;
         cpu_v <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            ppu_d[i] <= 8'h00;
            cpu_d[i] <= 8'h00;
         end
      end else begin
         ppu_v[0] <= ppu_req_in;
         cpu_v[0] <= cpu_rd_en;
         if (ppu_req_in)
            ppu_d[0] <= ppu_rd;
         if (cpu_rd_en)
            cpu_d[0] <= cpu_rd;
         for (int i = 1; i < READ_LATENCY; i++) begin
            ppu_v[i] <= ppu_v[i-1];
            cpu_v[i] <= cpu_v[i-1];
            if (ppu_v[i-1])
               ppu_d[i] <= ppu_d[i-1];
            if (cpu_v[i-1])
               cpu_d[i] <= cpu_d[i-1];
         end
      end
   end

   assign ppu_data_valid_out = ppu_v[READ_LATENCY-1];
   assign ppu_data_out       = ppu_d[READ_LATENCY-1];
   assign cpu_rvalid_out     = cpu_v[READ_LATENCY-1];
   assign cpu_rdata_out      = cpu_d[READ_LATENCY-1];

`ifdef OAM_DMA_EN

   typedef enum logic {
      IDLE,
      XFER
   } dma_state_t;

   localparam logic [7:0] CPB_LAST = 8'(DMA_CYCLES_PER_BYTE - 1);
   localparam logic [7:0] OAM_N    = 8'(OAM_BYTES);
   localparam logic [7:0] OAM_LAST = 8'(OAM_BYTES - 1);

   dma_state_t state, state_nx;
   logic [7:0] src, src_nx;
   logic [7:0] ridx, ridx_nx;
   logic [7:0] widx, widx_nx;
   logic [7:0] cnt, cnt_nx;
   logic       dma_start, dma_req;

   assign dma_start = cpu_we_in & (cpu_addr_in == 16'hFF46);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         src   <= 8'h00;
         ridx  <= 8'h00;
         widx  <= 8'h00;
         cnt   <= 8'h00;
      end else begin
         state <= state_nx;
         src   <= src_nx;
         ridx  <= ridx_nx;
         widx  <= widx_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      src_nx   = src;
      ridx_nx  = ridx;
      widx_nx  = widx;
      cnt_nx   = cnt;
      dma_req  = 1'b0;
      dma_wr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (dma_start) begin
               state_nx = XFER;
               src_nx   = cpu_wdata_in;
               ridx_nx  = 8'h00;
               widx_nx  = 8'h00;
               cnt_nx   = 8'h00;
            end
         end
         XFER: begin
            if (cnt == 8'h00 && ridx < OAM_N) begin
               dma_req = 1'b1;
               ridx_nx = ridx + 8'd1;
            end
            cnt_nx = (cnt == CPB_LAST) ? 8'h00 : cnt + 8'd1;
            if (dma_valid_in) begin
               dma_wr  = 1'b1;
               widx_nx = widx + 8'd1;
               if (widx == OAM_LAST)
                  state_nx = IDLE;
            end
            // A new source write restarts from byte 0.
            if (dma_start) begin
               state_nx = XFER;
               src_nx   = cpu_wdata_in;
               ridx_nx  = 8'h00;
               widx_nx  = 8'h00;
               cnt_nx   = 8'h00;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign dma_active     = state == XFER;
   assign dma_widx       = widx;
   assign dma_wdata      = dma_data_in;
   assign dma_req_out    = dma_req;
   assign dma_addr_out   = dma_req ? {src, ridx} : 16'h0000;
   assign dma_active_out = dma_active;

`else

   logic unused_dma;

   assign unused_dma     = ^{dma_data_in, dma_valid_in};
   assign dma_active     = 1'b0;
   assign dma_wr         = 1'b0;
   assign dma_widx       = 8'h00;
   assign dma_wdata      = 8'h00;
   assign dma_req_out    = 1'b0;
   assign dma_addr_out   = 16'h0000;
   assign dma_active_out = 1'b0;

`endif

endmodule
